// File: rtl/bsg_axi_pkg.sv
// Shared types and AXI encodings for the manycore AXI burst initiator.
package bsg_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5
  } axi_init_state_e;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // clog2 that never returns 0, so a width derived from it is always legal
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_axi_beat_counter.sv
// Beat counter for one AXI burst: synchronous clear, increment, last-beat flag.
module bsg_axi_beat_counter
  import bsg_axi_pkg::*;
#(
  parameter int burst_len_p = 4,
  localparam int cnt_width_lp = safe_clog2(burst_len_p)
)(
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic incr_i,
  output logic last_o
);

  localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(burst_len_p - 1);

  logic [cnt_width_lp-1:0] count_r;

  // count accepted beats; wraps harmlessly after the final beat
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (incr_i) begin
      count_r <= count_r + cnt_width_lp'(1'b1);
    end
  end

  assign last_o = (count_r == last_beat_lp);

endmodule

// File: rtl/bsg_manycore_axi_burst_initiator.sv
// Single-outstanding AXI4 INCR burst master for fixed-length cache-line reads/writes.
// Optional response/ID/rlast checking is enabled with BSG_AXI_INITIATOR_RESP_CHECK_EN.
module bsg_manycore_axi_burst_initiator
  import bsg_axi_pkg::*;
#(
  parameter int axi_id_width_p   = 4,
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 64,
  parameter int axi_burst_len_p  = 4
)(
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic                          req_v_i,
  output logic                          req_ready_o,
  input  logic                          req_write_i,
  input  logic [axi_addr_width_p-1:0]   req_addr_i,
  input  logic [axi_id_width_p-1:0]     req_id_i,

  input  logic                          wdata_v_i,
  output logic                          wdata_ready_o,
  input  logic [axi_data_width_p-1:0]   wdata_i,

  output logic                          rdata_v_o,
  input  logic                          rdata_ready_i,
  output logic [axi_data_width_p-1:0]   rdata_o,
  output logic                          rdata_last_o,

  output logic                          done_v_o,
  output logic                          done_err_o,

  output logic [axi_id_width_p-1:0]     axi_awid_o,
  output logic [axi_addr_width_p-1:0]   axi_awaddr_o,
  output logic [7:0]                    axi_awlen_o,
  output logic [2:0]                    axi_awsize_o,
  output logic [1:0]                    axi_awburst_o,
  output logic                          axi_awvalid_o,
  input  logic                          axi_awready_i,

  output logic [axi_data_width_p-1:0]   axi_wdata_o,
  output logic [axi_data_width_p/8-1:0] axi_wstrb_o,
  output logic                          axi_wlast_o,
  output logic                          axi_wvalid_o,
  input  logic                          axi_wready_i,

  input  logic [axi_id_width_p-1:0]     axi_bid_i,
  input  logic [1:0]                    axi_bresp_i,
  input  logic                          axi_bvalid_i,
  output logic                          axi_bready_o,

  output logic [axi_id_width_p-1:0]     axi_arid_o,
  output logic [axi_addr_width_p-1:0]   axi_araddr_o,
  output logic [7:0]                    axi_arlen_o,
  output logic [2:0]                    axi_arsize_o,
  output logic [1:0]                    axi_arburst_o,
  output logic                          axi_arvalid_o,
  input  logic                          axi_arready_i,

  input  logic [axi_id_width_p-1:0]     axi_rid_i,
  input  logic [axi_data_width_p-1:0]   axi_rdata_i,
  input  logic [1:0]                    axi_rresp_i,
  input  logic                          axi_rlast_i,
  input  logic                          axi_rvalid_i,
  output logic                          axi_rready_o
);

  localparam int lg_burst_bytes_lp = safe_clog2(axi_burst_len_p * axi_data_width_p / 8);
  localparam int lg_beat_bytes_lp  = safe_clog2(axi_data_width_p / 8);
  localparam logic [axi_addr_width_p-1:0] addr_mask_lp = {axi_addr_width_p{1'b1}} << lg_burst_bytes_lp;

  axi_init_state_e             state_r, state_n;
  logic [axi_addr_width_p-1:0] addr_r;
  logic [axi_id_width_p-1:0]   id_r;
  logic                        req_accept_s;
  logic                        cnt_clear_s, cnt_incr_s, cnt_last_s;
  logic                        wr_err_s, rd_err_s;

  bsg_axi_beat_counter #(.burst_len_p(axi_burst_len_p)) beat_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (cnt_clear_s),
    .incr_i  (cnt_incr_s),
    .last_o  (cnt_last_s)
  );

  // state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // burst address is aligned to the whole cache line
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_r <= '0;
      id_r   <= '0;
    end else if (req_accept_s) begin
      addr_r <= req_addr_i & addr_mask_lp;
      id_r   <= req_id_i;
    end
  end

  assign axi_awid_o    = id_r;
  assign axi_awaddr_o  = addr_r;
  assign axi_awlen_o   = 8'(axi_burst_len_p - 1);
  assign axi_awsize_o  = 3'(lg_beat_bytes_lp);
  assign axi_awburst_o = AXI_BURST_INCR;
  assign axi_arid_o    = id_r;
  assign axi_araddr_o  = addr_r;
  assign axi_arlen_o   = 8'(axi_burst_len_p - 1);
  assign axi_arsize_o  = 3'(lg_beat_bytes_lp);
  assign axi_arburst_o = AXI_BURST_INCR;
  assign axi_wdata_o   = wdata_i;
  assign axi_wstrb_o   = {(axi_data_width_p/8){1'b1}};
  assign rdata_o       = axi_rdata_i;

  // next-state and handshake outputs
  always_comb begin
    state_n       = state_r;
    req_ready_o   = 1'b0;
    req_accept_s  = 1'b0;
    cnt_clear_s   = 1'b0;
    cnt_incr_s    = 1'b0;
    wdata_ready_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_wlast_o   = 1'b0;
    rdata_v_o     = 1'b0;
    rdata_last_o  = 1'b0;
    axi_rready_o  = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_bready_o  = 1'b0;
    done_v_o      = 1'b0;
    done_err_o    = 1'b0;
    case (state_r)
      S_IDLE: begin
        req_ready_o = ~reset_i;
        cnt_clear_s = 1'b1;
        if (req_v_i && !reset_i) begin
          req_accept_s = 1'b1;
          state_n      = req_write_i ? S_WR_ADDR : S_RD_ADDR;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WR_ADDR: begin
        axi_awvalid_o = 1'b1;
        if (axi_awready_i) begin
          state_n = S_WR_DATA;
        end else begin
          state_n = S_WR_ADDR;
        end
      end
      S_WR_DATA: begin
        axi_wvalid_o  = wdata_v_i;
        wdata_ready_o = axi_wready_i;
        axi_wlast_o   = cnt_last_s;
        cnt_incr_s    = wdata_v_i & axi_wready_i;
        if (cnt_incr_s && cnt_last_s) begin
          state_n = S_WR_RESP;
        end else begin
          state_n = S_WR_DATA;
        end
      end
      S_WR_RESP: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) begin
          done_v_o   = 1'b1;
          done_err_o = wr_err_s;
          state_n    = S_IDLE;
        end else begin
          state_n = S_WR_RESP;
        end
      end
      S_RD_ADDR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) begin
          state_n = S_RD_DATA;
        end else begin
          state_n = S_RD_ADDR;
        end
      end
      S_RD_DATA: begin
        rdata_v_o    = axi_rvalid_i;
        axi_rready_o = rdata_ready_i;
        rdata_last_o = cnt_last_s;
        cnt_incr_s   = axi_rvalid_i & rdata_ready_i;
        if (cnt_incr_s && cnt_last_s) begin
          done_v_o   = 1'b1;
          done_err_o = rd_err_s;
          state_n    = S_IDLE;
        end else begin
          state_n = S_RD_DATA;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

`ifdef BSG_AXI_INITIATOR_RESP_CHECK_EN
  logic rd_beat_err_s, rd_err_r;

  assign wr_err_s      = (axi_bresp_i != AXI_RESP_OKAY) | (axi_bid_i != id_r);
  assign rd_beat_err_s = (axi_rresp_i != AXI_RESP_OKAY) | (axi_rid_i != id_r)
                       | (axi_rlast_i != cnt_last_s);
  assign rd_err_s      = rd_err_r | rd_beat_err_s;

  // sticky read error across the burst, cleared whenever idle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_err_r <= 1'b0;
    end else if (state_r == S_IDLE) begin
      rd_err_r <= 1'b0;
    end else if ((state_r == S_RD_DATA) && axi_rvalid_i && rdata_ready_i) begin
      rd_err_r <= rd_err_r | rd_beat_err_s;
    end
  end
`else
  logic unused_resp_s;

  assign wr_err_s      = 1'b0;
  assign rd_err_s      = 1'b0;
  assign unused_resp_s = ^{axi_bid_i, axi_bresp_i, axi_rid_i, axi_rresp_i, axi_rlast_i};
`endif

endmodule

// File: tb/tb_bsg_manycore_axi_burst_initiator.sv
// Directed self-checking bench: burst-4 instance for the main flows, burst-1 instance for single-beat bursts.
module tb_bsg_manycore_axi_burst_initiator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] wq[$];
  logic [63:0] rq[$];

  // shared data-side inputs
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [3:0]  req_id = 4'h0;
  logic [63:0] wdata = 64'h0, rdata = 64'h0;
  logic [3:0]  bid = 4'h0, rid = 4'h0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic        rlast = 1'b0;

  // burst-4 instance handshakes and outputs
  logic req_v = 1'b0, wdata_v = 1'b0, rdata_ready = 1'b0;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic req_ready, wdata_ready, rdata_v, rdata_last, done_v, done_err;
  logic [63:0] rdata_o, axi_wdata;
  logic [3:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic awvalid, wlast, wvalid, bready, arvalid, rready;

  // burst-1 instance handshakes and outputs
  logic b_req_v = 1'b0, b_wdata_v = 1'b0, b_rdata_ready = 1'b0;
  logic b_awready = 1'b0, b_wready = 1'b0, b_bvalid = 1'b0, b_arready = 1'b0, b_rvalid = 1'b0;
  logic b_req_ready, b_wdata_ready, b_rdata_v, b_rdata_last, b_done_v, b_done_err;
  logic [63:0] b_rdata_o, b_axi_wdata;
  logic [3:0]  b_awid, b_arid;
  logic [31:0] b_awaddr, b_araddr;
  logic [7:0]  b_awlen, b_arlen, b_wstrb;
  logic [2:0]  b_awsize, b_arsize;
  logic [1:0]  b_awburst, b_arburst;
  logic b_awvalid, b_wlast, b_wvalid, b_bready, b_arvalid, b_rready;

  bsg_manycore_axi_burst_initiator #(.axi_id_width_p(4), .axi_addr_width_p(32),
    .axi_data_width_p(64), .axi_burst_len_p(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_v_i(req_v), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_id_i(req_id),
    .wdata_v_i(wdata_v), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
    .rdata_v_o(rdata_v), .rdata_ready_i(rdata_ready), .rdata_o(rdata_o), .rdata_last_o(rdata_last),
    .done_v_o(done_v), .done_err_o(done_err),
    .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
    .axi_awburst_o(awburst), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wdata_o(axi_wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );

  bsg_manycore_axi_burst_initiator #(.axi_id_width_p(4), .axi_addr_width_p(32),
    .axi_data_width_p(64), .axi_burst_len_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset),
    .req_v_i(b_req_v), .req_ready_o(b_req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_id_i(req_id),
    .wdata_v_i(b_wdata_v), .wdata_ready_o(b_wdata_ready), .wdata_i(wdata),
    .rdata_v_o(b_rdata_v), .rdata_ready_i(b_rdata_ready), .rdata_o(b_rdata_o), .rdata_last_o(b_rdata_last),
    .done_v_o(b_done_v), .done_err_o(b_done_err),
    .axi_awid_o(b_awid), .axi_awaddr_o(b_awaddr), .axi_awlen_o(b_awlen), .axi_awsize_o(b_awsize),
    .axi_awburst_o(b_awburst), .axi_awvalid_o(b_awvalid), .axi_awready_i(b_awready),
    .axi_wdata_o(b_axi_wdata), .axi_wstrb_o(b_wstrb), .axi_wlast_o(b_wlast),
    .axi_wvalid_o(b_wvalid), .axi_wready_i(b_wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(b_bvalid), .axi_bready_o(b_bready),
    .axi_arid_o(b_arid), .axi_araddr_o(b_araddr), .axi_arlen_o(b_arlen), .axi_arsize_o(b_arsize),
    .axi_arburst_o(b_arburst), .axi_arvalid_o(b_arvalid), .axi_arready_i(b_arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(b_rvalid), .axi_rready_o(b_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input int aw_stall,
                             input logic [1:0] resp, input logic exp_err);
    int beat, cyc;
    logic pushed;
    req_v = 1'b1; req_write = 1'b1; req_addr = addr; req_id = id;
    wdata_v = 1'b1; wdata = 64'hDEAD;
    #1;
    check("wr_req_ready", req_ready, 1'b1);
    check("wr_idle_no_wvalid", wvalid, 1'b0);
    tick();
    req_v = 1'b0;
    for (int c = 0; c < aw_stall; c++) begin
      #1;
      check("aw_stall_valid", awvalid, 1'b1);
      check("aw_stall_addr", awaddr, addr & 32'hFFFF_FFE0);
      check("aw_stall_no_w", wvalid, 1'b0);
      tick();
    end
    awready = 1'b1;
    #1;
    check("awvalid", awvalid, 1'b1);
    check("awaddr", awaddr, addr & 32'hFFFF_FFE0);
    check("awid", awid, id);
    check("awlen", awlen, 8'd3);
    check("awsize", awsize, 3'd3);
    check("awburst", awburst, 2'b01);
    check("aw_no_w", wvalid, 1'b0);
    tick();
    awready = 1'b0;
    beat = 0; cyc = 0; pushed = 1'b0;
    while (beat < 4 && cyc < 40) begin
      wdata   = 64'hC0DE_0000_0000_0000 | (64'(addr) << 8) | 64'(beat);
      wdata_v = (cyc != 2);
      wready  = (cyc != 1);
      if (wdata_v && !pushed) begin
        wq.push_back(wdata);
        pushed = 1'b1;
      end
      #1;
      check("wvalid", wvalid, wdata_v);
      check("wdata_ready", wdata_ready, wready);
      if (wdata_v && wready) begin
        check("wdata", axi_wdata, wq.pop_front());
        check("wlast", wlast, beat == 3);
        check("wstrb", wstrb, 8'hFF);
        beat++;
        pushed = 1'b0;
      end
      cyc++;
      tick();
    end
    check("wr_beats_done", beat, 4);
    wdata_v = 1'b0; wready = 1'b0;
    #1;
    check("bready", bready, 1'b1);
    check("wr_no_early_done", done_v, 1'b0);
    tick();
    bvalid = 1'b1; bresp = resp; bid = id;
    #1;
    check("wr_done", done_v, 1'b1);
    check("wr_done_err", done_err, exp_err);
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    #1;
    check("wr_done_pulse", done_v, 1'b0);
    check("wr_idle_ready", req_ready, 1'b1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [3:0] id);
    int beat, cyc;
    logic pushed;
    req_v = 1'b1; req_write = 1'b0; req_addr = addr; req_id = id;
    rdata_ready = 1'b1;
    #1;
    check("rd_req_ready", req_ready, 1'b1);
    check("rd_idle_no_rready", rready, 1'b0);
    tick();
    req_v = 1'b0;
    arready = 1'b1;
    #1;
    check("arvalid", arvalid, 1'b1);
    check("araddr", araddr, addr & 32'hFFFF_FFE0);
    check("arid", arid, id);
    check("arlen", arlen, 8'd3);
    tick();
    arready = 1'b0;
    beat = 0; cyc = 0; pushed = 1'b0;
    while (beat < 4 && cyc < 40) begin
      rvalid      = (cyc != 1);
      rdata_ready = !(cyc == 3 || cyc == 4);
      rdata = 64'h5EED_0000_0000_0000 | (64'(addr) << 8) | 64'(beat);
      rid = id; rresp = 2'b00; rlast = (beat == 3);
      if (rvalid && !pushed) begin
        rq.push_back(rdata);
        pushed = 1'b1;
      end
      #1;
      check("rdata_v", rdata_v, rvalid);
      check("rready", rready, rdata_ready);
      if (rvalid && rdata_ready) begin
        check("rdata", rdata_o, rq.pop_front());
        check("rdata_last", rdata_last, beat == 3);
        check("rd_done", done_v, beat == 3);
        if (beat == 3) check("rd_done_err", done_err, 1'b0);
        beat++;
        pushed = 1'b0;
      end
      cyc++;
      tick();
    end
    check("rd_beats_done", beat, 4);
    rvalid = 1'b0; rdata_ready = 1'b0; rlast = 1'b0;
    #1;
    check("rd_idle_ready", req_ready, 1'b1);
    check("rd_queue_empty", rq.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_err;
    #2;
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_done", done_v, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_bready", bready, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_done_err", done_err, 1'b0);
    tick();

    write_burst(32'h1238, 4'h5, 5, 2'b00, 1'b0);
    tick();
    read_burst(32'h40, 4'h6);
    tick();

`ifdef BSG_AXI_INITIATOR_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    write_burst(32'h80, 4'h3, 0, 2'b10, exp_err);
    tick();

    // reset during the third write beat
    req_v = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_id = 4'h7;
    tick();
    req_v = 1'b0; awready = 1'b1;
    tick();
    awready = 1'b0; wdata_v = 1'b1; wready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_wvalid", wvalid, 1'b0);
    check("mid_rst_awvalid", awvalid, 1'b0);
    check("mid_rst_bready", bready, 1'b0);
    check("mid_rst_wdata_ready", wdata_ready, 1'b0);
    check("mid_rst_done", done_v, 1'b0);
    tick();
    reset = 1'b0; wdata_v = 1'b0; wready = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 1'b1);
    tick();
    read_burst(32'h40, 4'h2);
    tick();

    // single-beat bursts, back to back
    b_req_v = 1'b1; req_write = 1'b1; req_addr = 32'h104; req_id = 4'h1;
    #1;
    check("b1_req_ready", b_req_ready, 1'b1);
    tick();
    b_req_v = 1'b0; b_awready = 1'b1;
    #1;
    check("b1_awvalid", b_awvalid, 1'b1);
    check("b1_awaddr", b_awaddr, 32'h100);
    check("b1_awlen", b_awlen, 8'd0);
    tick();
    b_awready = 1'b0; b_wdata_v = 1'b1; b_wready = 1'b1; wdata = 64'h1111_2222_3333_4444;
    wq.push_back(wdata);
    #1;
    check("b1_wvalid", b_wvalid, 1'b1);
    check("b1_wlast", b_wlast, 1'b1);
    check("b1_wdata", b_axi_wdata, wq.pop_front());
    tick();
    b_wdata_v = 1'b0; b_wready = 1'b0;
    b_bvalid = 1'b1; bresp = 2'b00; bid = 4'h1;
    b_req_v = 1'b1; req_write = 1'b0; req_addr = 32'h20F;
    #1;
    check("b1_wr_done", b_done_v, 1'b1);
    check("b1_wr_done_err", b_done_err, 1'b0);
    check("b1_no_accept_on_done", b_req_ready, 1'b0);
    tick();
    b_bvalid = 1'b0;
    #1;
    check("b1_accept_after_done", b_req_ready, 1'b1);
    tick();
    b_req_v = 1'b0; b_arready = 1'b1;
    #1;
    check("b1_arvalid", b_arvalid, 1'b1);
    check("b1_araddr", b_araddr, 32'h208);
    tick();
    b_arready = 1'b0; b_rvalid = 1'b1; b_rdata_ready = 1'b1;
    rdata = 64'hABCD_0000_0000_0001; rid = 4'h1; rresp = 2'b00; rlast = 1'b1;
    rq.push_back(rdata);
    #1;
    check("b1_rdata_v", b_rdata_v, 1'b1);
    check("b1_rdata", b_rdata_o, rq.pop_front());
    check("b1_rdata_last", b_rdata_last, 1'b1);
    check("b1_rd_done", b_done_v, 1'b1);
    check("b1_rd_done_err", b_done_err, 1'b0);
    tick();
    b_rvalid = 1'b0; b_rdata_ready = 1'b0; rlast = 1'b0;
    #1;
    check("b1_idle_ready", b_req_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
